// File: rtl/matrix_link_host.sv
// Host-side initiator for the 2x2 matrix serial link: streams A and B out as 32 bytes,
// then collects the 32-byte sum/product reply and presents it atomically.
module matrix_link_host #(
    parameter int unsigned CLK_FRE        = 200,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] a_mat,
    input  logic [127:0] b_mat,
    output logic [127:0] sum_mat,
    output logic [127:0] prod_mat,
    output logic         busy,
    output logic         done,
    output logic         timeout_err,
    output logic [7:0]   tx_data,
    output logic         tx_data_valid,
    input  logic         tx_data_ready,
    input  logic [7:0]   rx_data,
    input  logic         rx_data_valid,
    output logic         rx_data_ready
);

    typedef enum logic [1:0] {StIdle, StSend, StRecv} state_e;

    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]  LastByte    = 5'd31;

    if (CLK_FRE == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("matrix_link_host: CLK_FRE and TIMEOUT_CYCLES must be non-zero");
    end

    state_e         state_q, state_d;
    logic [255:0]   tx_buf_q, tx_buf_d;
    logic [255:0]   rx_buf_q, rx_buf_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [31:0]    to_cnt_q, to_cnt_d;
    logic [127:0]   sum_q, sum_d;
    logic [127:0]   prod_q, prod_d;
    logic           done_q, done_d;
    logic           to_err_q, to_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            tx_buf_q <= '0;
            rx_buf_q <= '0;
            cnt_q    <= '0;
            to_cnt_q <= '0;
            sum_q    <= '0;
            prod_q   <= '0;
            done_q   <= 1'b0;
            to_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_buf_q <= tx_buf_d;
            rx_buf_q <= rx_buf_d;
            cnt_q    <= cnt_d;
            to_cnt_q <= to_cnt_d;
            sum_q    <= sum_d;
            prod_q   <= prod_d;
            done_q   <= done_d;
            to_err_q <= to_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_buf_d = tx_buf_q;
        rx_buf_d = rx_buf_q;
        cnt_d    = cnt_q;
        to_cnt_d = to_cnt_q;
        sum_d    = sum_q;
        prod_d   = prod_q;
        done_d   = 1'b0;
        to_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    tx_buf_d = {a_mat, b_mat};
                    cnt_d    = '0;
                    state_d  = StSend;
                end
            end

            StSend: begin
                // The head byte of tx_buf is always the one on tx_data.
                if (tx_data_ready) begin
                    if (cnt_q == LastByte) begin
                        cnt_d    = '0;
                        to_cnt_d = '0;
                        state_d  = StRecv;
                    end else begin
                        cnt_d    = cnt_q + 5'd1;
                        tx_buf_d = {tx_buf_q[247:0], 8'h00};
                    end
                end
            end

            StRecv: begin
                if (rx_data_valid) begin
                    rx_buf_d[8 * (31 - int'(cnt_q)) +: 8] = rx_data;
                    to_cnt_d = '0;
                    if (cnt_q == LastByte) begin
                        // Results load in one update so a partial reply is never visible.
                        sum_d   = rx_buf_d[255:128];
                        prod_d  = rx_buf_d[127:0];
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end else if (to_cnt_q == TimeoutLast) begin
                    to_err_d = 1'b1;
                    state_d  = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign tx_data_valid = (state_q == StSend);
    assign tx_data       = tx_data_valid ? tx_buf_q[255:248] : 8'h00;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign timeout_err   = to_err_q;
    assign sum_mat       = sum_q;
    assign prod_mat      = prod_q;
    assign rx_data_ready = 1'b1;

endmodule

// File: doc/matrix_link_host.md
# matrix_link_host

Host-side initiator for the 2x2 matrix UART link. On a start pulse it serializes two 2x2 matrices of 32-bit elements (A, then B) into 32 bytes on a byte-stream transmit interface. It then collects the 32-byte reply (element-wise sum, then product) from a byte-stream receive interface and presents both result matrices. It sits between the uart_tx/uart_rx byte engines and the host logic that drives the matrix accelerator over the serial link.

## Interface
- CLK_FRE, 200, clock frequency in MHz (informational; the UART engines take the same value)
- TIMEOUT_CYCLES, 2000000, maximum allowed idle gap in RECV, in clk cycles (10 ms at 200 MHz)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request; sampled only in IDLE
- a_mat  in  128  {A00,A01,A10,A11}; A00 at [127:96]
- b_mat  in  128  {B00,B01,B10,B11}; B00 at [127:96]
- sum_mat  out  128  {S00,S01,S10,S11}, first 16 reply bytes
- prod_mat  out  128  {P00,P01,P10,P11}, last 16 reply bytes
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the reply is complete
- timeout_err  out  1  one-cycle pulse on reply timeout
- tx_data  out  8  byte to the UART transmitter
- tx_data_valid  out  1  tx_data is valid
- tx_data_ready  in  1  transmitter accepts the byte this cycle
- rx_data  in  8  byte from the UART receiver
- rx_data_valid  in  1  one-cycle strobe; rx_data is valid
- rx_data_ready  out  1  tied to 1

## Operation
- The design uses one clock and one asynchronous, active-high reset.
- States are IDLE, SEND and RECV.
- IDLE:
  - On start, latch {a_mat,b_mat} into a 256-bit tx buffer, clear the byte counter, go to SEND.
  - rx bytes are discarded.
- SEND:
  - tx_data is tx buffer byte [counter], MSB first. Bytes 0-15 are A (A00[31:24] first); bytes 16-31 are B.
  - tx_data_valid is held high.
  - On tx_data_valid && tx_data_ready the counter increments.
  - When byte 31 is accepted: drop tx_data_valid, clear the counter and the timeout counter, go to RECV.
  - rx bytes arriving in SEND are discarded.
- RECV:
  - Each rx_data_valid shifts rx_data into a 256-bit rx buffer (first byte ends at [255:248]), increments the counter and clears the timeout counter.
  - On byte 31, load sum_mat = buffer[255:128] and prod_mat = buffer[127:0] in one update, pulse done, go to IDLE.
  - Outputs never show a partial reply.
- Timeout:
  - In RECV the timeout counter increments on every cycle with no rx byte.
  - When it reaches TIMEOUT_CYCLES-1, pulse timeout_err and go to IDLE.
  - sum_mat and prod_mat keep their previous values.
- start is ignored while busy.
- Arithmetic: the counter is 5 bits and the timeout counter is 32 bits; neither wraps within a transaction.

## Timing
- Reset values:
  - state IDLE.
  - tx_data 0, tx_data_valid 0.
  - sum_mat 0, prod_mat 0.
  - busy 0, done 0, timeout_err 0.
  - rx_data_ready 1.
- Send timing:
  - start high at edge t: busy=1 and tx_data_valid=1 with byte 0 from edge t+1.
  - tx_data advances on the edge after each handshake. It is stable while tx_data_valid && !tx_data_ready.
  - The fastest send, with ready held high, is 32 consecutive handshakes.
- Reply timing:
  - rx byte 31 strobed at edge r: sum_mat, prod_mat and done update at edge r+1, and busy=0 from r+1.
  - done and timeout_err never assert in the same cycle.
- rst asserted mid-transaction: all outputs return to reset values immediately; the partial transaction is lost.

## Test plan
- Reset:
  - Assert rst in SEND with tx_data_valid=1.
  - Required: tx_data_valid, busy, sum_mat and prod_mat go to 0 asynchronously; rx_data_ready=1.
- Byte order:
  - Stimulus: a_mat=0x00000001_00000002_00000003_00000004, b_mat=0x00000005_00000006_00000007_00000008, tx_data_ready held 1, start pulse.
  - Required: exactly 32 bytes 00 00 00 01 … 00 00 00 08, then tx_data_valid=0 and state RECV.
- Reply:
  - Stimulus: after the above, strobe 32 bytes encoding sums 6,8,10,12 and products 19,22,43,50.
  - Required: sum_mat=0x00000006_00000008_0000000A_0000000C, prod_mat=0x00000013_00000016_0000002B_00000032, done high for exactly one cycle, busy=0.
- Backpressure:
  - Stimulus: tx_data_ready randomly toggled.
  - Required: identical 32-byte sequence, no byte skipped or repeated, tx_data stable while stalled.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100; send only 10 reply bytes.
  - Required: timeout_err pulses 100 cycles after the 10th byte, sum_mat and prod_mat unchanged from the previous reply, state IDLE.
- Ignored events:
  - Stimulus 1: start pulses during SEND and RECV. Required: no restart and no change to the byte stream.
  - Stimulus 2: rx strobes during SEND. Required: they are discarded, and the reply is still captured correctly afterward.
